// File: rtl/exe_hazard_ctrl_pkg.sv
// Shared types and constants for the execute-stage hazard controller:
// forwarding select encodings and the EXE/MEM scoreboard slot record.
package exe_hazard_ctrl_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Slot destination field is sized for the widest supported register index;
   // narrower indices are zero-extended on entry.
   localparam int SLOT_DEST_W = 8;

   typedef struct packed {
      logic                   v;
      logic [SLOT_DEST_W-1:0] dest;
      logic                   wb;
      logic                   ld;
      logic                   s;
   } slot_t;

   localparam slot_t BUBBLE = '0;

   // The EXE-stage producer is younger than the MEM-stage one, so it wins.
   function automatic logic [1:0] fwd_pick(input logic hit_exe, input logic hit_mem);
      if (hit_exe)
         return FWD_MEM;
      else if (hit_mem)
         return FWD_WB;
      else
         return FWD_REG;
   endfunction

endpackage

// File: rtl/exe_hazard_ctrl_hz_match.sv
// Single scoreboard comparator: flags when a valid, writing slot produces
// the register that an enabled source operand reads.
module hz_match #(
   parameter int REG_W = 8
) (
   input  logic             slot_v,
   input  logic             slot_wb,
   input  logic [REG_W-1:0] slot_dest,
   input  logic [REG_W-1:0] src,
   input  logic             en,
   output logic             match
);

   assign match = en & slot_v & slot_wb & (slot_dest == src);

endmodule

// File: rtl/exe_hazard_ctrl.sv
// Execute-stage sequencing controller: tracks the EXE and MEM instructions,
// raises load-use/RAW stalls and branch flushes, and registers forwarding selects.
module exe_hazard_ctrl
   import exe_hazard_ctrl_pkg::*;
#(
   parameter int REG_W  = 4,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_two_src,
   input  logic [REG_W-1:0] id_dest,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  logic             id_s,
   input  logic             br_taken,
   output logic             stall,
   output logic             flush,
   output logic [1:0]       fwd_sel1,
   output logic [1:0]       fwd_sel2,
   output logic             sr_we,
   output logic [CNT_W-1:0] stall_cnt
);

   slot_t            exe_p1;
   slot_t            mem_p2;
   logic [1:0]       sel1_p1;
   logic [1:0]       sel2_p1;
   logic [CNT_W-1:0] cnt_q;

   logic [SLOT_DEST_W-1:0] src1_x;
   logic [SLOT_DEST_W-1:0] src2_x;
   logic                   en1;
   logic                   en2;
   logic                   m1e, m1m, m2e, m2m;
   logic                   hz;
   logic                   load_bubble;
   logic                   unused_mem_bits;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   assign src1_x = SLOT_DEST_W'(id_src1);
   assign src2_x = SLOT_DEST_W'(id_src2);
   assign en1    = id_valid;
   assign en2    = id_valid & id_two_src;

   // ID operands against the EXE and MEM producers
   hz_match #(.REG_W(SLOT_DEST_W)) u_m1e (
      .slot_v(exe_p1.v), .slot_wb(exe_p1.wb), .slot_dest(exe_p1.dest),
      .src(src1_x), .en(en1), .match(m1e)
   );
   hz_match #(.REG_W(SLOT_DEST_W)) u_m1m (
      .slot_v(mem_p2.v), .slot_wb(mem_p2.wb), .slot_dest(mem_p2.dest),
      .src(src1_x), .en(en1), .match(m1m)
   );
   hz_match #(.REG_W(SLOT_DEST_W)) u_m2e (
      .slot_v(exe_p1.v), .slot_wb(exe_p1.wb), .slot_dest(exe_p1.dest),
      .src(src2_x), .en(en2), .match(m2e)
   );
   hz_match #(.REG_W(SLOT_DEST_W)) u_m2m (
      .slot_v(mem_p2.v), .slot_wb(mem_p2.wb), .slot_dest(mem_p2.dest),
      .src(src2_x), .en(en2), .match(m2m)
   );

   always_comb begin
      hz = 1'b0;
      if (FWD_EN != 0)
         hz = exe_p1.ld & (m1e | m2e);
      else
         hz = m1e | m2e | m1m | m2m;
   end

   // A taken branch squashes the would-be stalled instruction, so flush wins.
   assign flush       = br_taken;
   assign stall       = hz & ~br_taken;
   assign load_bubble = stall | flush | ~id_valid;

   // ID -> EXE (p1) and EXE -> MEM (p2) boundary
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_p1  <= BUBBLE;
         mem_p2  <= BUBBLE;
         sel1_p1 <= FWD_REG;
         sel2_p1 <= FWD_REG;
         cnt_q   <= '0;
      end else begin
         mem_p2 <= exe_p1;
         if (load_bubble) begin
            exe_p1  <= BUBBLE;
            sel1_p1 <= FWD_REG;
            sel2_p1 <= FWD_REG;
         end else begin
            exe_p1 <= '{v: 1'b1, dest: SLOT_DEST_W'(id_dest), wb: id_wb_en,
                        ld: id_mem_r_en, s: id_s};
            sel1_p1 <= (FWD_EN != 0) ? fwd_pick(m1e, m1m) : FWD_REG;
            sel2_p1 <= (FWD_EN != 0) ? fwd_pick(m2e, m2m) : FWD_REG;
         end
         if (stall)
            cnt_q <= sat_inc(cnt_q);
      end
   end

   assign fwd_sel1  = sel1_p1;
   assign fwd_sel2  = sel2_p1;
   assign sr_we     = exe_p1.v & exe_p1.s;
   assign stall_cnt = cnt_q;

   assign unused_mem_bits = ^{mem_p2.ld, mem_p2.s};

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Scoreboard bench for exe_hazard_ctrl: three instances (forwarding on,
// forwarding off, 2-bit counter) driven by shared directed stimulus.
module tb_exe_hazard_ctrl;

   localparam int K_STALL = 0, K_FLUSH = 1, K_SEL1 = 2, K_SEL2 = 3, K_SRWE = 4, K_CNT = 5;
   localparam int DA = 0, DB = 1, DC = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_two_src, id_wb_en, id_mem_r_en, id_s, br_taken;
   logic [3:0] id_src1, id_src2, id_dest;

   logic        a_stall, a_flush, a_srwe, b_stall, b_flush, b_srwe, c_stall, c_flush, c_srwe;
   logic [1:0]  a_sel1, a_sel2, b_sel1, b_sel2, c_sel1, c_sel2;
   logic [15:0] a_cnt, b_cnt;
   logic [1:0]  c_cnt;

   typedef struct {
      string       tag;
      int          dut;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   nst;

   always #5 clk = ~clk;

   exe_hazard_ctrl #(.REG_W(4), .FWD_EN(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_r_en(id_mem_r_en), .id_s(id_s), .br_taken(br_taken),
      .stall(a_stall), .flush(a_flush), .fwd_sel1(a_sel1), .fwd_sel2(a_sel2),
      .sr_we(a_srwe), .stall_cnt(a_cnt)
   );

   exe_hazard_ctrl #(.REG_W(4), .FWD_EN(0), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_r_en(id_mem_r_en), .id_s(id_s), .br_taken(br_taken),
      .stall(b_stall), .flush(b_flush), .fwd_sel1(b_sel1), .fwd_sel2(b_sel2),
      .sr_we(b_srwe), .stall_cnt(b_cnt)
   );

   exe_hazard_ctrl #(.REG_W(4), .FWD_EN(1), .CNT_W(2)) dut_c (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
      .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
      .id_mem_r_en(id_mem_r_en), .id_s(id_s), .br_taken(br_taken),
      .stall(c_stall), .flush(c_flush), .fwd_sel1(c_sel1), .fwd_sel2(c_sel2),
      .sr_we(c_srwe), .stall_cnt(c_cnt)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] observe(input int dut, input int kind);
      logic [31:0] r;
      r = '0;
      case (dut)
         DA: case (kind)
               K_STALL: r = 32'(a_stall);
               K_FLUSH: r = 32'(a_flush);
               K_SEL1:  r = 32'(a_sel1);
               K_SEL2:  r = 32'(a_sel2);
               K_SRWE:  r = 32'(a_srwe);
               default: r = 32'(a_cnt);
             endcase
         DB: case (kind)
               K_STALL: r = 32'(b_stall);
               K_FLUSH: r = 32'(b_flush);
               K_SEL1:  r = 32'(b_sel1);
               K_SEL2:  r = 32'(b_sel2);
               K_SRWE:  r = 32'(b_srwe);
               default: r = 32'(b_cnt);
             endcase
         default: case (kind)
               K_STALL: r = 32'(c_stall);
               K_FLUSH: r = 32'(c_flush);
               K_SEL1:  r = 32'(c_sel1);
               K_SEL2:  r = 32'(c_sel2);
               K_SRWE:  r = 32'(c_srwe);
               default: r = 32'(c_cnt);
             endcase
      endcase
      return r;
   endfunction

   task automatic want(input string tag, input int dut, input int kind, input logic [31:0] v);
      exp_t e;
      e.tag  = tag;
      e.dut  = dut;
      e.kind = kind;
      e.exp  = v;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, observe(e.dut, e.kind), e.exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      drain();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                        input logic two, input logic [3:0] d, input logic wb,
                        input logic ld, input logic s, input logic br);
      id_valid    = v;
      id_src1     = s1;
      id_src2     = s2;
      id_two_src  = two;
      id_dest     = d;
      id_wb_en    = wb;
      id_mem_r_en = ld;
      id_s        = s;
      br_taken    = br;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
         cyc();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      want("rst_stall", DA, K_STALL, 0);
      want("rst_flush", DA, K_FLUSH, 0);
      want("rst_sel1", DA, K_SEL1, 0);
      want("rst_sel2", DA, K_SEL2, 0);
      want("rst_srwe", DA, K_SRWE, 0);
      want("rst_cnt", DA, K_CNT, 0);
      want("rst_cnt_c", DC, K_CNT, 0);
      cyc();
      rst = 1'b0;
      idle(2);

      // 1: ALU producer -> consumer, forwarded from EXE, no stall
      drive(1, 5, 6, 1, 1, 1, 0, 0, 0);
      want("t1_stall_p", DA, K_STALL, 0);
      cyc();
      drive(1, 1, 7, 1, 8, 1, 0, 1, 0);
      want("t1_stall_c", DA, K_STALL, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      want("t1_sel1", DA, K_SEL1, 1);
      want("t1_sel2", DA, K_SEL2, 0);
      want("t1_srwe", DA, K_SRWE, 1);
      cyc();
      idle(2);

      // 2: load-use on src2, one stall cycle, then WB forward
      drive(1, 9, 10, 0, 2, 1, 1, 0, 0);
      want("t2_stall_ld", DA, K_STALL, 0);
      cyc();
      drive(1, 11, 2, 1, 12, 1, 0, 1, 0);
      want("t2_stall", DA, K_STALL, 1);
      want("t2_flush", DA, K_FLUSH, 0);
      want("t2_cnt0", DA, K_CNT, 0);
      cyc();
      want("t2_stall_rel", DA, K_STALL, 0);
      want("t2_cnt1", DA, K_CNT, 1);
      want("t2_bub_srwe", DA, K_SRWE, 0);
      want("t2_bub_sel2", DA, K_SEL2, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      want("t2_sel2", DA, K_SEL2, 2);
      want("t2_sel1", DA, K_SEL1, 0);
      want("t2_srwe", DA, K_SRWE, 1);
      want("t2_cnt_hold", DA, K_CNT, 1);
      cyc();
      idle(2);

      // 3: r3 produced in both EXE and MEM, EXE wins
      drive(1, 13, 0, 0, 3, 1, 0, 0, 0);
      cyc();
      drive(1, 13, 0, 0, 3, 1, 0, 0, 0);
      cyc();
      drive(1, 3, 3, 0, 9, 1, 0, 0, 0);
      want("t3_stall", DA, K_STALL, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      want("t3_sel1", DA, K_SEL1, 1);
      want("t3_sel2_off", DA, K_SEL2, 0);
      cyc();
      idle(2);

      // 3b: producer only in MEM -> WB forward
      drive(1, 0, 0, 0, 14, 1, 0, 0, 0);
      cyc();
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      drive(1, 14, 0, 0, 1, 1, 0, 0, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      want("t3b_sel1", DA, K_SEL1, 2);
      cyc();
      idle(2);

      // 4: load-use coincident with taken branch
      drive(1, 0, 0, 0, 5, 1, 1, 0, 0);
      cyc();
      drive(1, 5, 0, 0, 6, 1, 0, 1, 1);
      want("t4_stall", DA, K_STALL, 0);
      want("t4_flush", DA, K_FLUSH, 1);
      want("t4_cnt", DA, K_CNT, 1);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      want("t4_bub_sel1", DA, K_SEL1, 0);
      want("t4_bub_srwe", DA, K_SRWE, 0);
      want("t4_cnt_hold", DA, K_CNT, 1);
      want("t4_flush_off", DA, K_FLUSH, 0);
      cyc();
      idle(2);

      // 5: forwarding disabled, RAW stalls two cycles
      drive(1, 0, 0, 0, 4, 1, 0, 0, 0);
      want("t5_stall_p", DB, K_STALL, 0);
      cyc();
      drive(1, 4, 0, 0, 9, 1, 0, 1, 0);
      want("t5_stall1", DB, K_STALL, 1);
      cyc();
      want("t5_stall2", DB, K_STALL, 1);
      want("t5_bub_srwe", DB, K_SRWE, 0);
      cyc();
      want("t5_stall_rel", DB, K_STALL, 0);
      cyc();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      want("t5_sel1", DB, K_SEL1, 0);
      want("t5_srwe", DB, K_SRWE, 1);
      cyc();
      idle(2);

      // 6: reset asserted in the middle of a stall
      drive(1, 0, 0, 0, 6, 1, 1, 0, 0);
      cyc();
      drive(1, 6, 0, 0, 7, 1, 0, 1, 0);
      want("t6_stall_pre", DA, K_STALL, 1);
      want("t6_cnt_pre", DA, K_CNT, 1);
      @(negedge clk);
      drain();
      #1 rst = 1'b1;
      #1;
      want("t6_rst_stall", DA, K_STALL, 0);
      want("t6_rst_sel1", DA, K_SEL1, 0);
      want("t6_rst_srwe", DA, K_SRWE, 0);
      want("t6_rst_cnt", DA, K_CNT, 0);
      want("t6_rst_cnt_c", DC, K_CNT, 0);
      drain();
      @(posedge clk);
      #1 rst = 1'b0;
      want("t6_post_stall", DA, K_STALL, 0);
      want("t6_post_flush", DA, K_FLUSH, 0);
      cyc();
      idle(2);

      // 6b: chained loads stall every other cycle; 2-bit counter saturates
      nst = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 7, 0, 0, 7, 1, 1, 0, 0);
         want($sformatf("t6_sat_stall%0d", i), DC, K_STALL, 32'(i % 2));
         want($sformatf("t6_sat_cnt%0d", i), DC, K_CNT, (nst > 3) ? 32'd3 : 32'(nst));
         cyc();
         if (i % 2 == 1) nst++;
      end
      idle(1);
      want("t6_sat_final", DC, K_CNT, 3);
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
